// File: rtl/mem_prog_loader.sv
// mem_prog_loader: byte-stream front-end that programs the instruction and data
// memories, then releases the CPU from reset after a cool-off period.
//
// Stream framing: HDR, LEN_LO, LEN_HI, LEN payload bytes [, CSUM].
//   HDR 0xA5 loads inst memory from address 0.
//   HDR 0x5A loads data memory from address DMEM_BASE.
//   HDR 0xC3 starts the cool-off count, after which cpu_reset_ is released (RUN).
//   In RUN, 0x3C puts the CPU back into reset and returns to IDLE.
//
// Build option: define LOADER_CSUM_EN to require a trailing XOR checksum byte per
// load frame. The default build (macro undefined) has no checksum byte.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid, in_data     stream byte and its valid
//   in_ready              loader can take a byte (independent of in_valid)
//   i_addr/i_wr_data/i_wr inst memory write port (1-cycle strobe)
//   d_addr/d_wr_data/d_wr data memory write port (1-cycle strobe)
//   cpu_reset_            active-low CPU reset, high only in RUN
//   busy                  frame or cool-off in progress
//   err                   sticky protocol error, cleared only by reset
module mem_prog_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DMEM_BASE = 8,
    parameter int unsigned MEM_LIMIT = 2048,
    parameter int unsigned COOLOFF   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] i_addr,
    output logic [7:0]        i_wr_data,
    output logic              i_wr,
    output logic [ADDR_W-1:0] d_addr,
    output logic [7:0]        d_wr_data,
    output logic              d_wr,
    output logic              cpu_reset_,
    output logic              busy,
    output logic              err
);

    // Sum width wide enough for start + 12-bit LEN without overflow.
    localparam int unsigned SUM_W = ((ADDR_W > 12) ? ADDR_W : 12) + 1;
    // Cool-off counter runs 0 .. COOLOFF-1.
    localparam int unsigned CNT_W = (COOLOFF > 1) ? $clog2(COOLOFF) : 1;

    localparam logic [7:0] HDR_INST = 8'hA5;
    localparam logic [7:0] HDR_DATA = 8'h5A;
    localparam logic [7:0] HDR_RUN  = 8'hC3;
    localparam logic [7:0] CMD_STOP = 8'h3C;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StCooloff,
        StRun,
        StErr
    } state_t;

`ifdef LOADER_CSUM_EN
    localparam state_t AFTER_PAYLOAD = StCsum;
`else
    localparam state_t AFTER_PAYLOAD = StIdle;
`endif

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [11:0]       rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sel_q, sel_d;      // 1 = data memory
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef LOADER_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    // One address/data register feeds both ports; only the strobes are separate.
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              i_wr_q, i_wr_d;
    logic              d_wr_q, d_wr_d;

    logic              ready_st;
    logic              accept;
    logic [11:0]       len_w;
    logic [ADDR_W-1:0] start_w;
    logic [SUM_W-1:0]  end_w;

    assign ready_st = !(state_q inside {StCooloff, StErr});
    // Masked by reset so nothing appears ready while reset is held.
    assign in_ready = ready_st & ~reset;
    assign accept   = in_valid & ready_st;

    assign len_w   = {in_data[3:0], len_lo_q};
    assign start_w = sel_q ? ADDR_W'(DMEM_BASE) : '0;
    assign end_w   = SUM_W'(start_w) + SUM_W'(len_w);

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
`ifdef LOADER_CSUM_EN
        csum_d    = csum_q;
`endif
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        i_wr_d    = 1'b0;
        d_wr_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (in_data)
                        HDR_INST: begin
                            sel_d   = 1'b0;
                            state_d = StLenLo;
                        end
                        HDR_DATA: begin
                            sel_d   = 1'b1;
                            state_d = StLenLo;
                        end
                        HDR_RUN: begin
                            cnt_d   = '0;
                            state_d = StCooloff;
                        end
                        default: state_d = StErr;
                    endcase
`ifdef LOADER_CSUM_EN
                    csum_d = 8'h00;
`endif
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    addr_d = start_w;
                    rem_d  = len_w;
                    if (end_w > SUM_W'(MEM_LIMIT)) begin
                        state_d = StErr;
                    end else if (len_w == 12'd0) begin
                        state_d = AFTER_PAYLOAD;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    i_wr_d    = ~sel_q;
                    d_wr_d    = sel_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - 12'd1;
`ifdef LOADER_CSUM_EN
                    csum_d    = csum_q ^ in_data;
`endif
                    if (rem_q == 12'd1) begin
                        state_d = AFTER_PAYLOAD;
                    end
                end
            end
`ifdef LOADER_CSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? StIdle : StErr;
                end
            end
`endif
            StCooloff: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(COOLOFF - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    if (in_data == CMD_STOP) begin
                        state_d = StIdle;
                    end else if (in_data == HDR_INST || in_data == HDR_DATA) begin
                        state_d = StErr;
                    end
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            len_lo_q  <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef LOADER_CSUM_EN
            csum_q    <= '0;
`endif
            wr_addr_q <= '0;
            wr_data_q <= '0;
            i_wr_q    <= 1'b0;
            d_wr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
`ifdef LOADER_CSUM_EN
            csum_q    <= csum_d;
`endif
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            i_wr_q    <= i_wr_d;
            d_wr_q    <= d_wr_d;
        end
    end

    assign i_addr     = wr_addr_q;
    assign i_wr_data  = wr_data_q;
    assign i_wr       = i_wr_q;
    assign d_addr     = wr_addr_q;
    assign d_wr_data  = wr_data_q;
    assign d_wr       = d_wr_q;
    assign cpu_reset_ = (state_q == StRun);
    assign busy       = state_q inside {StLenLo, StLenHi, StData, StCsum, StCooloff};
    assign err        = (state_q == StErr);

endmodule

// File: tb/tb_mem_prog_loader.sv
// Self-checking bench for mem_prog_loader. Expected writes are derived from the
// framing rules: payload byte j of a frame goes to base+j of the selected memory,
// visible in the cycle after the edge that accepted it.
module tb_mem_prog_loader;

    localparam int ADDR_W    = 12;
    localparam int DMEM_BASE = 8;
    localparam int MEM_LIMIT = 2048;
    localparam int COOLOFF   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] i_addr;
    logic [7:0]        i_wr_data;
    logic              i_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [7:0]        d_wr_data;
    logic              d_wr;
    logic              cpu_reset_;
    logic              busy;
    logic              err;

    mem_prog_loader #(
        .ADDR_W    (ADDR_W),
        .DMEM_BASE (DMEM_BASE),
        .MEM_LIMIT (MEM_LIMIT),
        .COOLOFF   (COOLOFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_wr       (i_wr),
        .d_addr     (d_addr),
        .d_wr_data  (d_wr_data),
        .d_wr       (d_wr),
        .cpu_reset_ (cpu_reset_),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic              dmem;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [31:0]       cyc;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];

    // Collect every strobed write together with the cycle it was seen in.
    always @(negedge clk) begin
        wr_t w;
        if (i_wr) begin
            w.dmem = 1'b0; w.addr = i_addr; w.data = i_wr_data; w.cyc = cyc;
            act_q.push_back(w);
        end
        if (d_wr) begin
            w.dmem = 1'b1; w.addr = d_addr; w.data = d_wr_data; w.cyc = cyc;
            act_q.push_back(w);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, required finish within 5ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b, output logic [31:0] acc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
            acc      = '1;
            in_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        logic [31:0] acc;
        send(b, acc);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Payload byte j of a frame into the selected memory.
    task automatic pay(input bit dmem, input int j, input logic [7:0] b);
        logic [31:0] acc;
        wr_t         w;
        send(b, acc);
        w.dmem = dmem;
        w.addr = ADDR_W'((dmem ? DMEM_BASE : 0) + j);
        w.data = b;
        w.cyc  = acc;
        exp_q.push_back(w);
    endtask

    task automatic load_frame(input bit dmem, input int len, input int gap_max);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        logic [3:0] junk;
        send_b(dmem ? 8'h5A : 8'hA5);
        send_b(len[7:0]);
        junk = 4'($urandom);
        send_b({junk, len[11:8]});
        for (int j = 0; j < len; j++) begin
            idle($urandom_range(0, gap_max));
            b = 8'($urandom);
            x = x ^ b;
            pay(dmem, j, b);
        end
`ifdef LOADER_CSUM_EN
        send_b(x);
`endif
    endtask

    task automatic check_writes(input string tag);
        int n;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr"}, 64'(act_q[i]), 64'(exp_q[i]));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_cpu_reset_", {63'd0, cpu_reset_}, 64'd0);
        chk("rst_i_wr", {63'd0, i_wr}, 64'd0);
        chk("rst_d_wr", {63'd0, d_wr}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_i_addr", 64'(i_addr), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed inst load
        send_b(8'hA5);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        send_b(8'h03);
        send_b(8'h00);
        pay(1'b0, 0, 8'h11);
        pay(1'b0, 1, 8'h22);
        pay(1'b0, 2, 8'h33);
`ifdef LOADER_CSUM_EN
        send_b(8'h00);
`endif
        check_writes("t1");
        chk("t1_err", {63'd0, err}, 64'd0);
        chk("t1_busy_end", {63'd0, busy}, 64'd0);

        // Directed data load, then RUN with cool-off timing
        send_b(8'h5A);
        send_b(8'h02);
        send_b(8'h00);
        pay(1'b1, 0, 8'hAA);
        pay(1'b1, 1, 8'h55);
`ifdef LOADER_CSUM_EN
        send_b(8'hFF);
`endif
        check_writes("t2");
        send_b(8'hC3);
        // Cycle 1 is the first cycle after the accepting edge; release at COOLOFF+1.
        chk("cool_in_ready", {63'd0, in_ready}, 64'd0);
        chk("cool_busy", {63'd0, busy}, 64'd1);
        for (int j = 1; j <= COOLOFF + 1; j++) begin
            chk("cool_cpu_reset_", {63'd0, cpu_reset_}, (j > COOLOFF) ? 64'd1 : 64'd0);
            if (j <= COOLOFF) @(negedge clk);
        end
        chk("run_in_ready", {63'd0, in_ready}, 64'd1);
        chk("run_busy", {63'd0, busy}, 64'd0);

        // RUN drops non-command bytes, 0x3C returns to IDLE with CPU in reset
        send_b(8'h00);
        send_b(8'hC3);
        send_b(8'h77);
        chk("run_keep_cpu", {63'd0, cpu_reset_}, 64'd1);
        check_writes("run_drop");
        send_b(8'h3C);
        chk("stop_cpu_reset_", {63'd0, cpu_reset_}, 64'd0);
        chk("stop_busy", {63'd0, busy}, 64'd0);
        chk("stop_in_ready", {63'd0, in_ready}, 64'd1);
        chk("stop_err", {63'd0, err}, 64'd0);

        // Random frames with random valid gaps
        for (int f = 0; f < 6; f++) begin
            load_frame(1'($urandom_range(0, 1)), $urandom_range(1, 24), 3);
            check_writes("rand");
            chk("rand_err", {63'd0, err}, 64'd0);
        end

        // LEN=0 frames: no writes
        load_frame(1'b1, 0, 0);
        load_frame(1'b0, 0, 0);
        check_writes("len0");
        chk("len0_busy", {63'd0, busy}, 64'd0);
        chk("len0_err", {63'd0, err}, 64'd0);

        // Bounds: 8 + 2040 = 2048 is legal, back-to-back bytes
        load_frame(1'b1, MEM_LIMIT - DMEM_BASE, 0);
        check_writes("bound_ok");
        chk("bound_ok_err", {63'd0, err}, 64'd0);

        // Bounds: 8 + 2041 overflows
        send_b(8'h5A);
        send_b(8'hF9);
        send_b(8'h07);
        chk("bound_bad_err", {63'd0, err}, 64'd1);
        chk("bound_bad_ready", {63'd0, in_ready}, 64'd0);
        chk("bound_bad_cpu", {63'd0, cpu_reset_}, 64'd0);
        check_writes("bound_bad");
        pulse_reset();
        chk("rst2_err", {63'd0, err}, 64'd0);
        chk("rst2_ready", {63'd0, in_ready}, 64'd1);

        // Inst bound: 0 + 2049 overflows
        send_b(8'hA5);
        send_b(8'h01);
        send_b(8'h08);
        chk("ibound_err", {63'd0, err}, 64'd1);
        check_writes("ibound");
        pulse_reset();

        // Bad header, reset, then a normal frame
        send_b(8'h77);
        chk("badhdr_err", {63'd0, err}, 64'd1);
        chk("badhdr_ready", {63'd0, in_ready}, 64'd0);
        pulse_reset();
        chk("rst3_err", {63'd0, err}, 64'd0);
        chk("rst3_busy", {63'd0, busy}, 64'd0);
        load_frame(1'b0, 4, 1);
        check_writes("after_rst");
        chk("after_rst_err", {63'd0, err}, 64'd0);

        // Load header while in RUN (send waits through cool-off)
        send_b(8'hC3);
        send_b(8'h5A);
        chk("runload_err", {63'd0, err}, 64'd1);
        chk("runload_cpu", {63'd0, cpu_reset_}, 64'd0);
        pulse_reset();

        // Reset mid-frame drops the in-flight strobe; the issued write stands
        send_b(8'h5A);
        send_b(8'h03);
        send_b(8'h00);
        pay(1'b1, 0, 8'($urandom));
        chk("midrst_d_wr_before", {63'd0, d_wr}, 64'd1);
        #1 reset = 1'b1;
        #1 chk("midrst_d_wr_after", {63'd0, d_wr}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_writes("midrst");

        // Trailing byte after the payload
        send_b(8'hA5);
        send_b(8'h01);
        send_b(8'h00);
        pay(1'b0, 0, 8'h12);
`ifdef LOADER_CSUM_EN
        send_b(8'h13);  // wrong checksum
`else
        send_b(8'h77);  // parsed as an unknown header
`endif
        chk("trail_err", {63'd0, err}, 64'd1);
        check_writes("trail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
